// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and widths for the fetch controller.
//   ADDR_W  - instruction address width (8)
//   INSTR_W - instruction word width (32)
//   state_e - FSM state encoding, also visible on fetch_ctrl.state_out
package fetch_ctrl_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;
  localparam int STATE_W = 3;
  localparam int PERF_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RESP  = 3'd2,
    S_HALT  = 3'd3
  } state_e;

endpackage

// File: rtl/fetch_ctrl_pc_unit.sv
// fetch_ctrl_pc_unit: program counter register with incrementer and
// redirect mux. Priority: reset > load_reset > load_redirect > advance.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (pc <= RESET_PC)
//   load_reset     - reload RESET_PC (restart from HALT)
//   load_redirect  - load redirect_pc
//   advance        - pc <= pc + PC_STEP, wrapping modulo 2**ADDR_W
//   redirect_pc    - redirect target
//   pc             - current program counter
module fetch_ctrl_pc_unit
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0] PC_STEP  = 8'd4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_reset,
  input  logic              load_redirect,
  input  logic              advance,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_reset) begin
      pc_d = RESET_PC;
    end else if (load_redirect) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      // natural ADDR_W-bit wrap: 8'hFC + 4 -> 8'h00
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller in front of a synchronous ROM.
// FSM IDLE -> FETCH (one rom_en cycle) -> RESP (instruction presented)
// -> FETCH ... with redirect, halt and restart handling.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start                 - leave IDLE/HALT and begin fetching
//   halt_req              - stop fetching (wins over redirect and start)
//   redirect_valid/_pc    - branch target, honoured in FETCH and RESP only
//   rom_addr, rom_en      - ROM request; rom_data returns one cycle later
//   rom_data              - ROM read data
//   instr_out, pc_out     - instruction and its address to the decoder
//   instr_valid/ready     - decoder handshake
//   state_out             - current FSM state (state_e encoding)
// Optional (macro FETCH_CTRL_PERF_EN):
//   fetch_count           - saturating count of transfers
//   stall_count           - saturating count of RESP cycles with ready low
//
// Handshake: instr_valid/instr_out/pc_out are held stable until
// instr_valid & instr_ready (a transfer) is seen on a rising edge; the
// controller never withdraws valid except on redirect, halt or reset.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0] PC_STEP  = 8'd4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_en,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [STATE_W-1:0] state_out
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  fetch_count,
  output logic [PERF_W-1:0]  stall_count
`endif
);

  state_e             state_q, state_d;
  logic               rom_en_q, rom_en_d;
  logic               instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  // fresh_q marks the first RESP cycle, when the ROM output is the
  // instruction itself; after that the captured copy in instr_q is used.
  logic               fresh_q, fresh_d;

  logic               xfer;
  logic               load_reset, load_redirect, advance;
  logic [ADDR_W-1:0]  pc;

  assign xfer = instr_valid_q & instr_ready;

  fetch_ctrl_pc_unit #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk           (clk),
    .reset         (reset),
    .load_reset    (load_reset),
    .load_redirect (load_redirect),
    .advance       (advance),
    .redirect_pc   (redirect_pc),
    .pc            (pc)
  );

  always_comb begin
    state_d       = state_q;
    load_reset    = 1'b0;
    load_redirect = 1'b0;
    advance       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (redirect_valid) begin
          state_d       = S_FETCH;
          load_redirect = 1'b1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (halt_req) begin
          // a transfer in the halting cycle still completes
          state_d = S_HALT;
          advance = xfer;
        end else if (redirect_valid) begin
          // redirect wins over a simultaneous transfer: no pc advance
          state_d       = S_FETCH;
          load_redirect = 1'b1;
        end else if (xfer) begin
          state_d = S_FETCH;
          advance = 1'b1;
        end
      end
      S_HALT: begin
        if (start && !halt_req) begin
          state_d    = S_FETCH;
          load_reset = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rom_en_d      = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_RESP);
    fresh_d       = (state_q == S_FETCH) && (state_d == S_RESP);
    pc_out_d      = fresh_d ? pc : pc_out_q;
    instr_d       = fresh_q ? rom_data : instr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rom_en_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_out_q      <= '0;
      instr_q       <= '0;
      fresh_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_en_q      <= rom_en_d;
      instr_valid_q <= instr_valid_d;
      pc_out_q      <= pc_out_d;
      instr_q       <= instr_d;
      fresh_q       <= fresh_d;
    end
  end

  assign rom_addr    = pc;
  assign rom_en      = rom_en_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_out_q;
  assign instr_out   = fresh_q ? rom_data : instr_q;
  assign state_out   = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [PERF_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (xfer && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 1'b1;
    if ((state_q == S_RESP) && !instr_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl (default parameters).
// Build with +define+FETCH_CTRL_PERF_EN to also check the counters.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [7:0] RST_PC = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        instr_ready = 1'b0;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [31:0] rom_data = 32'h0;
  logic [31:0] instr_out;
  logic [7:0]  pc_out;
  logic        instr_valid;
  logic [2:0]  state_out;
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_en         (rom_en),
    .rom_data       (rom_data),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .state_out      (state_out)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  // synchronous ROM: data appears the cycle after rom_en
  logic [31:0] rom [256];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behaviour described by flags: idle (never started), halted, holding an
  // instruction for the decoder; otherwise a ROM request is in flight.
  bit          m_idle, m_halted, m_holding;
  int          m_pc;
  logic [7:0]  m_pc_out;
  logic [31:0] m_instr;
  int          m_fetch, m_stall;

  task automatic model_reset();
    m_idle = 1; m_halted = 0; m_holding = 0;
    m_pc = int'(RST_PC); m_pc_out = 8'h00; m_instr = 32'h0;
    m_fetch = 0; m_stall = 0;
  endtask

  task automatic check_model();
    logic [2:0] exp_state;
    bit fetching;
    fetching = !m_idle && !m_halted && !m_holding;
    exp_state = m_idle ? S_IDLE : m_halted ? S_HALT : m_holding ? S_RESP : S_FETCH;
    chk("state_out", {29'd0, state_out}, {29'd0, exp_state});
    chk("rom_en", {31'd0, rom_en}, {31'd0, fetching});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
    if (fetching) chk("rom_addr", {24'd0, rom_addr}, m_pc);
    if (m_holding) begin
      chk("pc_out", {24'd0, pc_out}, {24'd0, m_pc_out});
      chk("instr_out", instr_out, m_instr);
    end
    if (m_idle) begin
      chk("idle_rom_addr", {24'd0, rom_addr}, {24'd0, RST_PC});
      chk("idle_pc_out", {24'd0, pc_out}, 32'd0);
      chk("idle_instr_out", instr_out, 32'd0);
    end
`ifdef FETCH_CTRL_PERF_EN
    chk("fetch_count", {16'd0, fetch_count}, m_fetch);
    chk("stall_count", {16'd0, stall_count}, m_stall);
`endif
  endtask

  task automatic update_model();
    bit xfer;
    if (reset) begin
      model_reset();
      return;
    end
    xfer = m_holding && instr_ready;
    if (xfer && m_fetch < 65535) m_fetch++;
    if (m_holding && !instr_ready && m_stall < 65535) m_stall++;
    if (m_idle) begin
      if (start) m_idle = 0;
    end else if (m_halted) begin
      if (start && !halt_req) begin
        m_halted = 0;
        m_pc = int'(RST_PC);
      end
    end else if (halt_req) begin
      m_halted = 1;
      m_holding = 0;
      if (xfer) m_pc = (m_pc + 4) % 256;
    end else if (redirect_valid) begin
      m_pc = int'(redirect_pc);
      m_holding = 0;
    end else if (!m_holding) begin
      m_holding = 1;
      m_pc_out = m_pc[7:0];
      m_instr = rom[m_pc];
    end else if (xfer) begin
      m_holding = 0;
      m_pc = (m_pc + 4) % 256;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    check_model();
    update_model();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit st, input bit hr, input bit rv, input logic [7:0] rpc,
                     input bit rdy, input bit rst);
    start = st; halt_req = hr; redirect_valid = rv; redirect_pc = rpc;
    instr_ready = rdy; reset = rst;
    tick();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       st, hr, rv;
    logic [7:0] rpc;
    logic       rdy;
    logic [2:0] e_state;
    logic       e_en;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h00500093;

    // start with ready high: rom_addr 0,4,8; then 5 stall cycles on pc 8
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, S_IDLE,  1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, S_FETCH, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, S_RESP,  1'b0, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, S_FETCH, 1'b1, 8'h04, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, S_RESP,  1'b0, 8'h00, 1'b1, 8'h04};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, S_FETCH, 1'b1, 8'h08, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, S_RESP,  1'b0, 8'h00, 1'b1, 8'h08};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, S_RESP,  1'b0, 8'h00, 1'b1, 8'h08};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, S_RESP,  1'b0, 8'h00, 1'b1, 8'h08};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, S_RESP,  1'b0, 8'h00, 1'b1, 8'h08};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, S_RESP,  1'b0, 8'h00, 1'b1, 8'h08};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, S_RESP,  1'b0, 8'h00, 1'b1, 8'h08};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, S_FETCH, 1'b1, 8'h0C, 1'b0, 8'h00};

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_state", {29'd0, state_out}, {29'd0, S_IDLE});
    chk("rst_rom_en", {31'd0, rom_en}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_rom_addr", {24'd0, rom_addr}, {24'd0, RST_PC});
    chk("rst_pc_out", {24'd0, pc_out}, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      start = vecs[i].st; halt_req = vecs[i].hr; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; instr_ready = vecs[i].rdy;
      @(negedge clk);
      check_model();
      chk($sformatf("vec%0d_state", i), {29'd0, state_out}, {29'd0, vecs[i].e_state});
      chk($sformatf("vec%0d_rom_en", i), {31'd0, rom_en}, {31'd0, vecs[i].e_en});
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_en) chk($sformatf("vec%0d_addr", i), {24'd0, rom_addr}, {24'd0, vecs[i].e_addr});
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_pc_out", i), {24'd0, pc_out}, {24'd0, vecs[i].e_pc});
        chk($sformatf("vec%0d_instr", i), instr_out, rom[vecs[i].e_pc]);
      end
      if (i == 2) chk("first_instr", instr_out, 32'h00500093);
`ifdef FETCH_CTRL_PERF_EN
      if (i == 11) chk("stall_count_5", {16'd0, stall_count}, 32'd5);
`endif
      update_model();
      @(posedge clk);
      #1;
    end

    // redirect in RESP with ready high: no advance, fetch from 8'h40
    cyc(0, 0, 0, 8'h00, 0, 1);
    cyc(1, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 8'h00, 1, 0);
    chk("redir_pre_valid", {31'd0, instr_valid}, 32'd1);
    cyc(0, 0, 1, 8'h40, 1, 0);
    chk("redir_rom_addr", {24'd0, rom_addr}, 32'h40);
    chk("redir_rom_en", {31'd0, rom_en}, 32'd1);
    chk("redir_valid_drop", {31'd0, instr_valid}, 32'd0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    chk("redir_pc_out", {24'd0, pc_out}, 32'h40);

    // wrap: pc 8'hFC + 4 -> 8'h00
    cyc(0, 0, 1, 8'hFC, 0, 0);
    chk("wrap_pre_addr", {24'd0, rom_addr}, 32'hFC);
    cyc(0, 0, 0, 8'h00, 0, 0);
    chk("wrap_pc_out", {24'd0, pc_out}, 32'hFC);
    cyc(0, 0, 0, 8'h00, 1, 0);
    chk("wrap_rom_addr", {24'd0, rom_addr}, 32'h00);
    chk("wrap_rom_en", {31'd0, rom_en}, 32'd1);

    // halt + redirect together in FETCH: halt wins; start restarts at RESET_PC
    cyc(0, 0, 1, 8'h20, 0, 0);
    chk("halt_pre_addr", {24'd0, rom_addr}, 32'h20);
    cyc(0, 1, 1, 8'h80, 0, 0);
    chk("halt_state", {29'd0, state_out}, {29'd0, S_HALT});
    chk("halt_rom_en", {31'd0, rom_en}, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    cyc(1, 1, 0, 8'h00, 0, 0);
    chk("halt_prio_state", {29'd0, state_out}, {29'd0, S_HALT});
    cyc(1, 0, 0, 8'h00, 0, 0);
    chk("restart_state", {29'd0, state_out}, {29'd0, S_FETCH});
    chk("restart_rom_addr", {24'd0, rom_addr}, {24'd0, RST_PC});

    // reset while holding an instruction
    cyc(0, 0, 1, 8'h30, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);
    chk("rresp_valid", {31'd0, instr_valid}, 32'd1);
    cyc(1, 0, 0, 8'h00, 1, 1);
    chk("rresp_state", {29'd0, state_out}, {29'd0, S_IDLE});
    chk("rresp_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("rresp_pc", {24'd0, rom_addr}, {24'd0, RST_PC});

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)),
          $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, the PC value loaded on reset and on start from HALT.
REQ-002 SHALL have parameter PC_STEP, default 4, the PC increment per accepted instruction.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, leaves IDLE/HALT and begins fetching.
REQ-006 SHALL have port halt_req, input, 1, stops fetching after the current cycle.
REQ-007 SHALL have port redirect_valid, input, 1, a branch/jump target is present this cycle.
REQ-008 SHALL have port redirect_pc, input, 8, the redirect target address.
REQ-009 SHALL have port rom_addr, output, 8, the address to the synchronous instruction ROM.
REQ-010 SHALL have port rom_en, output, 1, the ROM read strobe; data returns one cycle later.
REQ-011 SHALL have port rom_data, input, 32, the ROM read data.
REQ-012 SHALL have port instr_out, output, 32, the held instruction to the decoder.
REQ-013 SHALL have port pc_out, output, 8, the address of instr_out.
REQ-014 SHALL have port instr_valid, output, 1, instr_out/pc_out are valid.
REQ-015 SHALL have port instr_ready, input, 1, the decoder accepts; transfer = instr_valid & instr_ready.
REQ-016 SHALL have port state_out, output, 3, the current FSM state encoding.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, RESP, HALT.
REQ-018 SHALL, in IDLE, assert no rom_en or instr_valid, and on start go to FETCH.
REQ-019 SHALL, in FETCH, drive rom_addr=pc with rom_en=1 for exactly one cycle, then go to RESP.
REQ-020 SHALL, on entering RESP, register rom_data into instr_out and pc into pc_out, with instr_valid=1 the cycle after FETCH (1-cycle latency).
REQ-021 SHALL hold instr_out, pc_out and instr_valid stable in RESP until transfer.
REQ-022 SHALL, on transfer, set pc <= pc+PC_STEP modulo 256 (252+4 -> 0), deassert instr_valid next cycle, and go to FETCH.
REQ-023 SHALL, on redirect_valid in FETCH or RESP, set pc <= redirect_pc, drop any pending instruction (instr_valid=0 next cycle) and go to FETCH; redirect takes priority over a simultaneous transfer.
REQ-024 SHALL ignore redirect_valid in IDLE and HALT.
REQ-025 SHALL, on halt_req in FETCH or RESP, go to HALT next cycle, deasserting rom_en and instr_valid; a transfer in the same cycle completes and still advances pc.
REQ-026 SHALL give halt_req priority over a simultaneous redirect_valid; redirect is discarded.
REQ-027 SHALL, in HALT, on start reload pc=RESET_PC and go to FETCH; halt_req has priority over start.
REQ-028 SHALL ignore start in FETCH and RESP.

Reset
REQ-029 SHALL, on reset, set state=IDLE, pc=RESET_PC, rom_addr=RESET_PC, rom_en=0, instr_valid=0, instr_out=0, pc_out=0.
REQ-030 SHALL let reset override all other inputs in any state, including mid-RESP; pending instruction is lost.

Configuration
REQ-031 SHALL, with FETCH_CTRL_PERF_EN defined, add output fetch_count (16 bits): reset 0, +1 per transfer, saturating at 16'hFFFF, and output stall_count (16 bits): +1 per RESP cycle with instr_ready=0, saturating.
REQ-032 SHALL, without FETCH_CTRL_PERF_EN, omit both ports and counters; all other behaviour is identical.

Structure
REQ-033 SHALL place the state enum, the 8-bit address width and the 32-bit instruction width constants in shared package fetch_ctrl_pkg.
REQ-034 SHALL implement the PC register, the incrementer and the redirect mux as sub-module fetch_ctrl_pc_unit; FSM and output registers stay in fetch_ctrl.

Verification
REQ-035 SHALL cover reset, start, ready held 1, ROM[0]=32'h00500093 -> rom_addr sequence 0,4,8; first instr_valid two cycles after start with pc_out=0 and instr_out=32'h00500093.
REQ-036 SHALL cover instr_ready=0 for 5 cycles in RESP -> instr_out/pc_out unchanged, rom_en=0, stall_count=5 (PERF_EN).
REQ-037 SHALL cover redirect_valid=1, redirect_pc=8'h40 in RESP with ready=1 -> no pc advance, next rom_addr=8'h40.
REQ-038 SHALL cover pc=8'hFC with transfer -> next rom_addr=8'h00.
REQ-039 SHALL cover halt_req and redirect_valid together in FETCH -> HALT, rom_en=0; then start -> rom_addr=RESET_PC.
REQ-040 SHALL cover reset asserted in RESP with instr_valid=1 -> next cycle state=IDLE, instr_valid=0, pc=RESET_PC.
